// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: data-bus req/ready handshake, store lane
// steering, load formatting and the MEM/WB register. Optional MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses.
module mem_stage #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            ex_mem_alu_result,
  input  logic [31:0]            ex_mem_reg2,
  input  logic [4:0]             ex_mem_rd,
  input  logic                   ex_mem_reg_write,
  input  logic                   ex_mem_mem_write,
  input  logic                   ex_mem_mem_read,
  input  logic [2:0]             ex_mem_funct3,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [31:0]            dmem_addr,
  output logic [31:0]            dmem_wdata,
  output logic [3:0]             dmem_be,
  input  logic                   dmem_ready,
  input  logic [31:0]            dmem_rdata,
  output logic                   mem_stall,
  output logic [31:0]            mem_wb_result,
  output logic [4:0]             mem_wb_rd,
  output logic                   mem_wb_reg_write,
  output logic                   mem_misalign,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 r_state;
  logic [31:0]            r_wb_result;
  logic [4:0]             r_wb_rd;
  logic                   r_wb_reg_write;
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  logic        w_mem_op;
  logic        w_access;
  logic        w_trap;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_mem_op = ex_mem_mem_read | ex_mem_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;

  // funct3[1:0] encodes the size: 01 half, 10 word
  assign w_trap = w_mem_op &
                  (((ex_mem_funct3[1:0] == 2'b01) & ex_mem_alu_result[0]) |
                   ((ex_mem_funct3[1:0] == 2'b10) & (ex_mem_alu_result[1:0] != 2'b00)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_misalign <= 1'b0;
    else          r_misalign <= w_trap;
  end
  assign mem_misalign = r_misalign;
`else
  assign w_trap       = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  assign w_access  = w_mem_op & ~w_trap;
  assign mem_stall = w_access & ~dmem_ready;
  assign dmem_req  = reset_n & (w_access | (r_state == S_WAIT));
  assign dmem_we   = w_access & ex_mem_mem_write;
  assign dmem_addr = {ex_mem_alu_result[31:2], 2'b00};

  always_comb begin
    dmem_wdata = ex_mem_reg2;
    dmem_be    = 4'b1111;
    if (ex_mem_mem_write) begin
      case (ex_mem_funct3[1:0])
        2'b00: begin
          dmem_wdata = {4{ex_mem_reg2[7:0]}};
          dmem_be    = 4'b0001 << ex_mem_alu_result[1:0];
        end
        2'b01: begin
          dmem_wdata = {2{ex_mem_reg2[15:0]}};
          dmem_be    = ex_mem_alu_result[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          dmem_wdata = ex_mem_reg2;
          dmem_be    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    case (ex_mem_alu_result[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = ex_mem_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ex_mem_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_access && !dmem_ready) r_state <= S_WAIT;
        S_WAIT:  if (dmem_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A stall inserts a bubble; rd and result keep their last values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_result    <= 32'h0;
      r_wb_rd        <= 5'h0;
      r_wb_reg_write <= 1'b0;
    end else if (mem_stall) begin
      r_wb_reg_write <= 1'b0;
    end else begin
      r_wb_result    <= ex_mem_mem_read ? w_load_data : ex_mem_alu_result;
      r_wb_rd        <= ex_mem_rd;
      r_wb_reg_write <= ex_mem_reg_write & ~w_trap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stall_cycles <= '0;
    else if (mem_stall && (r_stall_cycles != '1))
      r_stall_cycles <= r_stall_cycles + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  assign mem_wb_result    = r_wb_result;
  assign mem_wb_rd        = r_wb_rd;
  assign mem_wb_reg_write = r_wb_reg_write;
  assign stall_cycles     = r_stall_cycles;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads, stores, ALU pass-through,
// wait states, back-to-back access, misalignment and reset during WAIT.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] alu, reg2, rdata;
  logic [4:0]  rd;
  logic        rw, mw, mr, ready;
  logic [2:0]  f3;
  logic        req, we, stall, wb_rw, misalign;
  logic [31:0] addr, wdata, wb_result;
  logic [3:0]  be;
  logic [4:0]  wb_rd;
  logic [31:0] stall_cnt;

  int tests_run = 0;
  int failed    = 0;

  mem_stage #(.STALL_CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_mem_alu_result(alu), .ex_mem_reg2(reg2), .ex_mem_rd(rd),
    .ex_mem_reg_write(rw), .ex_mem_mem_write(mw), .ex_mem_mem_read(mr),
    .ex_mem_funct3(f3),
    .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_wdata(wdata),
    .dmem_be(be), .dmem_ready(ready), .dmem_rdata(rdata),
    .mem_stall(stall), .mem_wb_result(wb_result), .mem_wb_rd(wb_rd),
    .mem_wb_reg_write(wb_rw), .mem_misalign(misalign), .stall_cycles(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic w, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst,
                       input logic wen, input logic rdy, input logic [31:0] rdat);
    mr = r; mw = w; f3 = fn; alu = a; reg2 = d; rd = dst; rw = wen;
    ready = rdy; rdata = rdat;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd1, 1'b1, 1'b0, 32'h0);
    #12;
    tests_run++; if (req !== 1'b0) begin failed++; $display("FAIL reset_req got %0b want 0", req); end
    tests_run++; if (wb_result !== 32'h0 || wb_rd !== 5'd0 || wb_rw !== 1'b0)
      begin failed++; $display("FAIL reset_wb got %h/%0d/%0b want 0/0/0", wb_result, wb_rd, wb_rw); end
    tests_run++; if (stall_cnt !== 32'd0 || misalign !== 1'b0)
      begin failed++; $display("FAIL reset_cnt got %0d/%0b want 0/0", stall_cnt, misalign); end
    nop();
    @(negedge clk); reset_n = 1'b1;
    step();
  endtask

  task automatic test_lw();
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    tests_run++; if (req !== 1'b1 || we !== 1'b0 || be !== 4'hF || addr !== 32'h100 || stall !== 1'b0)
      begin failed++; $display("FAIL lw_bus got req=%0b we=%0b be=%h addr=%h stall=%0b want 1 0 f 100 0", req, we, be, addr, stall); end
    step();
    tests_run++; if (wb_result !== 32'hDEADBEEF || wb_rd !== 5'd5 || wb_rw !== 1'b1)
      begin failed++; $display("FAIL lw_wb got %h/%0d/%0b want deadbeef/5/1", wb_result, wb_rd, wb_rw); end
  endtask

  task automatic test_lb_wait();
    drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (stall !== 1'b1 || req !== 1'b1 || addr !== 32'h100)
        begin failed++; $display("FAIL lb_stall%0d got stall=%0b req=%0b addr=%h want 1 1 100", i, stall, req, addr); end
      step();
      tests_run++; if (wb_rw !== 1'b0)
        begin failed++; $display("FAIL lb_bubble%0d got %0b want 0", i, wb_rw); end
    end
    ready = 1'b1; rdata = 32'h80112233;
    @(negedge clk);
    tests_run++; if (stall !== 1'b0 || req !== 1'b1)
      begin failed++; $display("FAIL lb_done got stall=%0b req=%0b want 0 1", stall, req); end
    step();
    tests_run++; if (wb_result !== 32'hFFFFFF80 || wb_rd !== 5'd9 || wb_rw !== 1'b1)
      begin failed++; $display("FAIL lb_wb got %h/%0d/%0b want ffffff80/9/1", wb_result, wb_rd, wb_rw); end
    tests_run++; if (stall_cnt !== 32'd3)
      begin failed++; $display("FAIL lb_cnt got %0d want 3", stall_cnt); end
  endtask

  task automatic test_stores();
    drive(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    tests_run++; if (we !== 1'b1 || be !== 4'b1100 || wdata !== 32'hABCDABCD || addr !== 32'h200)
      begin failed++; $display("FAIL sh_bus got we=%0b be=%b wdata=%h addr=%h want 1 1100 abcdabcd 200", we, be, wdata, addr); end
    step();
    tests_run++; if (wb_rw !== 1'b0)
      begin failed++; $display("FAIL sh_wb got %0b want 0", wb_rw); end
    drive(1'b0, 1'b1, 3'b000, 32'h101, 32'h00000012, 5'd0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    tests_run++; if (be !== 4'b0010 || wdata !== 32'h12121212)
      begin failed++; $display("FAIL sb_bus got be=%b wdata=%h want 0010 12121212", be, wdata); end
    step();
  endtask

  task automatic test_load_fmt();
    drive(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 32'h80010000);
    step();
    tests_run++; if (wb_result !== 32'hFFFF8001)
      begin failed++; $display("FAIL lh_wb got %h want ffff8001", wb_result); end
    drive(1'b1, 1'b0, 3'b100, 32'h100, 32'h0, 5'd4, 1'b1, 1'b1, 32'h000000F0);
    step();
    tests_run++; if (wb_result !== 32'h000000F0)
      begin failed++; $display("FAIL lbu_wb got %h want 000000f0", wb_result); end
  endtask

  task automatic test_alu();
    drive(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd7, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    tests_run++; if (req !== 1'b0 || stall !== 1'b0)
      begin failed++; $display("FAIL alu_bus got req=%0b stall=%0b want 0 0", req, stall); end
    step();
    tests_run++; if (wb_result !== 32'h55 || wb_rd !== 5'd7 || wb_rw !== 1'b1)
      begin failed++; $display("FAIL alu_wb got %h/%0d/%0b want 55/7/1", wb_result, wb_rd, wb_rw); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 5'd3, 1'b1, 1'b1, 32'h11223344);
    step();
    tests_run++; if (wb_result !== 32'h11223344 || wb_rw !== 1'b1)
      begin failed++; $display("FAIL b2b_lw got %h/%0b want 11223344/1", wb_result, wb_rw); end
    drive(1'b0, 1'b1, 3'b010, 32'h108, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    tests_run++; if (req !== 1'b1 || we !== 1'b1 || be !== 4'hF || wdata !== 32'hCAFEF00D || addr !== 32'h108)
      begin failed++; $display("FAIL b2b_sw got req=%0b we=%0b be=%h wdata=%h addr=%h", req, we, be, wdata, addr); end
    step();
    tests_run++; if (wb_rw !== 1'b0)
      begin failed++; $display("FAIL b2b_sw_wb got %0b want 0", wb_rw); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b0, 3'b101, 32'h301, 32'h0, 5'd6, 1'b1, 1'b1, 32'h1234BEEF);
    @(negedge clk);
`ifdef MEM_MISALIGN_TRAP_EN
    tests_run++; if (req !== 1'b0 || stall !== 1'b0)
      begin failed++; $display("FAIL mis_bus got req=%0b stall=%0b want 0 0", req, stall); end
    step();
    tests_run++; if (misalign !== 1'b1 || wb_rw !== 1'b0)
      begin failed++; $display("FAIL mis_trap got misalign=%0b rw=%0b want 1 0", misalign, wb_rw); end
    nop();
    step();
    tests_run++; if (misalign !== 1'b0)
      begin failed++; $display("FAIL mis_pulse got %0b want 0", misalign); end
`else
    tests_run++; if (req !== 1'b1 || addr !== 32'h300 || misalign !== 1'b0)
      begin failed++; $display("FAIL mis_bus got req=%0b addr=%h mis=%0b want 1 300 0", req, addr, misalign); end
    step();
    tests_run++; if (wb_result !== 32'h0000BEEF || wb_rw !== 1'b1 || misalign !== 1'b0)
      begin failed++; $display("FAIL mis_wb got %h/%0b/%0b want 0000beef/1/0", wb_result, wb_rw, misalign); end
`endif
  endtask

  task automatic test_reset_wait();
    drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd8, 1'b1, 1'b0, 32'h0);
    step();
    @(negedge clk);
    tests_run++; if (req !== 1'b1 || stall !== 1'b1)
      begin failed++; $display("FAIL rw_wait got req=%0b stall=%0b want 1 1", req, stall); end
    reset_n = 1'b0;
    #1;
    tests_run++; if (req !== 1'b0)
      begin failed++; $display("FAIL rw_req got %0b want 0", req); end
    tests_run++; if (wb_result !== 32'h0 || wb_rd !== 5'd0 || wb_rw !== 1'b0 || stall_cnt !== 32'd0 || misalign !== 1'b0)
      begin failed++; $display("FAIL rw_outs got %h/%0d/%0b/%0d/%0b want all 0", wb_result, wb_rd, wb_rw, stall_cnt, misalign); end
    nop();
    step();
    @(negedge clk); reset_n = 1'b1;
    step();
    tests_run++; if (wb_rw !== 1'b0)
      begin failed++; $display("FAIL rw_nowb got %0b want 0", wb_rw); end
    drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd2, 1'b1, 1'b1, 32'hA5A5A5A5);
    @(negedge clk);
    tests_run++; if (req !== 1'b1 || stall !== 1'b0)
      begin failed++; $display("FAIL rw_idle got req=%0b stall=%0b want 1 0", req, stall); end
    step();
    tests_run++; if (wb_result !== 32'hA5A5A5A5 || wb_rd !== 5'd2 || wb_rw !== 1'b1 || stall_cnt !== 32'd0)
      begin failed++; $display("FAIL rw_after got %h/%0d/%0b/%0d want a5a5a5a5/2/1/0", wb_result, wb_rd, wb_rw, stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_wait();
    test_stores();
    test_load_fmt();
    test_alu();
    test_back_to_back();
    test_misalign();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline.
- Sits between the EX/MEM register (its input) and the register-file writeback (its output).
- Issues loads and stores to the data-memory bus with a req/ready handshake, and stalls upstream while an access is outstanding.
- Formats load data by width and sign, then registers the MEM/WB pipeline state consumed by writeback and by the EX forwarding path.

Parameters:
- STALL_CNT_W, 32, width of the stall-cycle performance counter (saturating).

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- ex_mem_alu_result  in  32  ALU result; the memory address for loads and stores.
- ex_mem_reg2  in  32  store data (rs2).
- ex_mem_rd  in  5  destination register.
- ex_mem_reg_write  in  1  writeback enable.
- ex_mem_mem_write  in  1  store.
- ex_mem_mem_read  in  1  load.
- ex_mem_funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dmem_req  out  1  bus request.
- dmem_we  out  1  bus write.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  access complete; rdata valid this cycle.
- dmem_rdata  in  32  read word.
- mem_stall  out  1  combinational hold request to IF/ID/EX.
- mem_wb_result  out  32  registered writeback value.
- mem_wb_rd  out  5  registered destination register.
- mem_wb_reg_write  out  1  registered writeback enable.
- mem_misalign  out  1  misaligned-access flag (see Optional Feature).
- stall_cycles  out  STALL_CNT_W  count of cycles with mem_stall=1.

Behaviour:
- mem_op = ex_mem_mem_read | ex_mem_mem_write.
- FSM states: IDLE, WAIT.
  - IDLE: if mem_op, assert dmem_req in the same cycle (combinational). If dmem_ready=1, the access completes with zero wait and the FSM stays in IDLE. Otherwise go to WAIT.
  - WAIT: hold dmem_req=1 and all bus outputs stable. Go to IDLE on the cycle dmem_ready=1.
- dmem_ready must not depend combinationally on dmem_req; the slave registers it.
- mem_stall = mem_op & ~dmem_ready (any state). Upstream holds the ex_mem_* inputs stable while mem_stall=1.
- Stores:
  - SB: wdata = {4{rs2[7:0]}}, be = 0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata = rs2, be = 1111.
  - Loads drive dmem_we=0, be=1111.
- Load formatting: select the lane from addr[1:0] (H uses addr[1]). B/H sign-extend; BU/HU zero-extend; W passes the word.
- MEM/WB register, updated each posedge clk:
  - mem_stall=1: insert a bubble (mem_wb_reg_write<=0; rd and result hold).
  - Otherwise: result <= formatted load data if mem_read, else ex_mem_alu_result. rd and reg_write <= ex_mem_* values.
  - Stores complete with mem_wb_reg_write <= ex_mem_reg_write (0 for valid stores).
  - Load or ALU result to rd=0: passed through unchanged; the register file ignores x0.
- Latency:
  - Non-memory ops: 1 cycle.
  - Memory ops: 1 + N cycles, where N = cycles with dmem_ready=0 after the request.
- stall_cycles: +1 per cycle with mem_stall=1, saturating at all-ones.
- Reset (reset_n=0, asynchronous):
  - FSM -> IDLE; mem_wb_result=0, mem_wb_rd=0, mem_wb_reg_write=0, mem_misalign=0, stall_cycles=0.
  - dmem_req forced 0 while reset_n=0.
  - Reset mid-WAIT abandons the access; no writeback occurs.
- Simultaneous events: dmem_ready with a new op in the same IDLE cycle completes that op. The next instruction is presented the following cycle and may request back-to-back.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - An H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, raises no dmem_req and no stall.
  - MEM/WB gets reg_write=0, and mem_misalign pulses 1 for one cycle (registered).
- Not defined:
  - mem_misalign is tied to 0.
  - Misaligned addresses are truncated: H uses addr[1], W ignores addr[1:0]. The access proceeds normally.

Test Plan:
- LW, addr 0x100, rdata 0xDEADBEEF, ready same cycle -> no stall; next cycle mem_wb_result=0xDEADBEEF, reg_write=1.
- LB, addr 0x103, rdata 0x80112233, ready after 3 cycles -> mem_stall high 3 cycles, 3 bubbles; result=0xFFFFFF80; stall_cycles=3.
- SH, addr 0x202, rs2 0x0000ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, addr=0x200; mem_wb_reg_write=0.
- ADD result 0x55 to rd=7 (no mem op) -> dmem_req=0, next cycle result=0x55, rd=7, reg_write=1.
- LHU, addr 0x301, under MEM_MISALIGN_TRAP_EN -> no dmem_req, mem_misalign=1 for one cycle, reg_write=0. Without the macro -> access at 0x300, lane 0.
- reset_n low during WAIT -> dmem_req=0 immediately; all outputs reset values; after release the FSM is in IDLE.
